message_slicer_fc: RTL and testbench

MESSAGE_SLICER_FC -- requirements
Module: message_slicer_fc

---
 rtl/message_slicer_fc.sv | 97 +++++++++
 tb/tb_message_slicer_fc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/message_slicer_fc.sv
// Slices wide input words into WIDTH-bit entries, queues them in a circular
// buffer and streams them out one slice per cycle behind a registered output.
module message_slicer_fc #(
  parameter int N_SLICES          = 2,
  parameter int LOG_N_SLICES      = 1,
  parameter int WIDTH             = 33,
  parameter int BUFFER_LENGTH     = 64,
  parameter int LOG_BUFFER_LENGTH = 6,
  parameter int MSB_FIRST         = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*N_SLICES-1:0] in_data,
  input  logic [LOG_N_SLICES:0]     in_count,
  input  logic                      in_nd,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_nd,
  input  logic                      out_ready,
  output logic                      error
);

  localparam logic [LOG_BUFFER_LENGTH:0] BUF_LEN = (LOG_BUFFER_LENGTH+1)'(BUFFER_LENGTH);

  logic [WIDTH-1:0]             mem [BUFFER_LENGTH];
  logic [LOG_BUFFER_LENGTH-1:0] wr_ptr;
  logic [LOG_BUFFER_LENGTH-1:0] rd_ptr;
  logic [LOG_BUFFER_LENGTH:0]   occupancy;
  logic [LOG_BUFFER_LENGTH:0]   free_entries;
  logic [LOG_BUFFER_LENGTH:0]   add_cnt;
  logic [LOG_BUFFER_LENGTH:0]   sub_cnt;
  logic                         count_legal;
  logic                         has_room;
  logic                         accept;
  logic                         pop;

  logic                         wr_en   [N_SLICES];
  logic [LOG_BUFFER_LENGTH-1:0] wr_addr [N_SLICES];
  logic [WIDTH-1:0]             wr_val  [N_SLICES];

  // Acceptance and pop both look at occupancy before the edge, so a slot
  // freed by this cycle's pop cannot be claimed by a same-cycle write.
  always_comb begin
    free_entries = BUF_LEN - occupancy;
    count_legal  = (in_count != '0) && (32'(in_count) <= 32'(N_SLICES));
    has_room     = 32'(free_entries) >= 32'(in_count);
    accept       = in_nd && count_legal && has_room;
    pop          = (occupancy != '0) && (!out_nd || out_ready);
    in_ready     = rst_n && (32'(free_entries) >= 32'(N_SLICES));
    add_cnt      = accept ? (LOG_BUFFER_LENGTH+1)'(in_count) : '0;
    sub_cnt      = pop ? (LOG_BUFFER_LENGTH+1)'(1) : '0;
  end

  // Slot j from the write pointer takes the slice that must leave j-th.
  always_comb begin
    for (int unsigned j = 0; j < N_SLICES; j++) begin
      int unsigned src;
      src        = 0;
      wr_en[j]   = accept && (j < 32'(in_count));
      if (wr_en[j]) begin
        if (MSB_FIRST != 0) src = 32'(in_count) - 32'd1 - j;
        else                src = j;
      end
      wr_addr[j] = wr_ptr + LOG_BUFFER_LENGTH'(j);
      wr_val[j]  = in_data[src*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < N_SLICES; j++) begin
      if (wr_en[j]) mem[wr_addr[j]] <= wr_val[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      out_data  <= '0;
      out_nd    <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + LOG_BUFFER_LENGTH'(in_count);
      if (pop)    rd_ptr <= rd_ptr + LOG_BUFFER_LENGTH'(1);
      occupancy <= occupancy + add_cnt - sub_cnt;
      if (pop) begin
        out_data <= mem[rd_ptr];
        out_nd   <= 1'b1;
      end else if (out_ready) begin
        out_nd   <= 1'b0;
      end
      if (in_nd && !accept) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_message_slicer_fc.sv
// Directed bench for message_slicer_fc: an MSB-first and an LSB-first instance
// share stimulus; per-instance queues hold the slice order each must emit.
module tb_message_slicer_fc;

  logic        clk;
  logic        rst_n;
  logic [65:0] in_data;
  logic [1:0]  in_count;
  logic        in_nd;
  logic        out_ready;

  logic        in_ready1, out_nd1, error1;
  logic [32:0] out_data1;
  logic        in_ready0, out_nd0, error0;
  logic [32:0] out_data0;

  logic [32:0] q1[$];
  logic [32:0] q0[$];
  int total;
  int bad;

  message_slicer_fc #(.N_SLICES(2), .LOG_N_SLICES(1), .WIDTH(33), .BUFFER_LENGTH(8),
                      .LOG_BUFFER_LENGTH(3), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_count(in_count), .in_nd(in_nd),
    .in_ready(in_ready1), .out_data(out_data1), .out_nd(out_nd1), .out_ready(out_ready),
    .error(error1)
  );

  message_slicer_fc #(.N_SLICES(2), .LOG_N_SLICES(1), .WIDTH(33), .BUFFER_LENGTH(8),
                      .LOG_BUFFER_LENGTH(3), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_count(in_count), .in_nd(in_nd),
    .in_ready(in_ready0), .out_data(out_data0), .out_nd(out_nd0), .out_ready(out_ready),
    .error(error0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Consumer side: every transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_ready && out_nd1) begin
      total++;
      assert (q1.size() != 0) else begin
        bad++;
        $error("FAIL out1_unexpected: observed=%h expected=none", out_data1);
      end
      if (q1.size() != 0) check("out1_data", {33'd0, out_data1}, {33'd0, q1.pop_front()});
    end
    if (rst_n && out_ready && out_nd0) begin
      total++;
      assert (q0.size() != 0) else begin
        bad++;
        $error("FAIL out0_unexpected: observed=%h expected=none", out_data0);
      end
      if (q0.size() != 0) check("out0_data", {33'd0, out_data0}, {33'd0, q0.pop_front()});
    end
  end

  task automatic push_word(input logic [65:0] d, input logic [1:0] c);
    for (int j = 0; j < 2; j++) begin
      if (j < int'(c)) q0.push_back(d[j*33 +: 33]);
    end
    for (int j = 1; j >= 0; j--) begin
      if (j < int'(c)) q1.push_back(d[j*33 +: 33]);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic send(input logic [65:0] d, input logic [1:0] c, input bit acc);
    in_data  = d;
    in_count = c;
    in_nd    = 1'b1;
    if (acc) push_word(d, c);
    @(posedge clk); #1;
    in_nd    = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_q1_left"}, 66'(q1.size()), 66'd0);
    check({tag, "_q0_left"}, 66'(q0.size()), 66'd0);
    check({tag, "_out_nd_idle"}, {64'd0, out_nd1, out_nd0}, 66'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    check({tag, "_in_ready_rst"}, {64'd0, in_ready1, in_ready0}, 66'd0);
    @(posedge clk); #1;
    check({tag, "_out_nd_rst"}, {64'd0, out_nd1, out_nd0}, 66'd0);
    check({tag, "_error_rst"}, {64'd0, error1, error0}, 66'd0);
    check({tag, "_out_data_rst"}, {out_data1, out_data0}, 66'd0);
    rst_n = 1'b1;
    #1;
    check({tag, "_in_ready_idle"}, {64'd0, in_ready1, in_ready0}, 66'd3);
  endtask

  function automatic logic [65:0] rnd66();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[65:0];
  endfunction

  initial begin
    logic [65:0] w;
    logic [32:0] held;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_count  = '0;
    in_nd     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    // Two-slice word: MSB instance emits slice 1 then slice 0, one cycle latency.
    w = {33'h1_2345_6789, 33'h0_0BAD_BEEF};
    send(w, 2'd2, 1'b1);
    check("lat_edge_k", {64'd0, out_nd1, out_nd0}, 66'd0);
    @(posedge clk); #1;
    check("lat_edge_k1_nd", {64'd0, out_nd1, out_nd0}, 66'd3);
    check("lat_edge_k1_data1", {33'd0, out_data1}, {33'd0, w[65:33]});
    check("lat_edge_k1_data0", {33'd0, out_data0}, {33'd0, w[32:0]});
    @(posedge clk); #1;
    check("lat_edge_k2_data1", {33'd0, out_data1}, {33'd0, w[32:0]});
    drain("two_slice");

    // Single-slice word.
    send({33'h1_FFFF_FFFF, 33'd5}, 2'd1, 1'b1);
    drain("one_slice");
    check("one_slice_error", {64'd0, error1, error0}, 66'd0);

    // Continuous traffic driven whenever in_ready; pointers wrap repeatedly.
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i >= 3) check("gapless_out_nd", {65'd0, out_nd1}, 66'd1);
      in_nd = in_ready1;
      if (in_ready1) begin
        in_data  = rnd66();
        in_count = 2'(1 + (i % 2));
        push_word(in_data, in_count);
      end
      @(posedge clk); #1;
    end
    in_nd = 1'b0;
    drain("stream");
    check("stream_error", {64'd0, error1, error0}, 66'd0);

    // Backpressure: four words fit, fifth overflows.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rnd66(), 2'd2, i < 4);
    check("ovf_error", {64'd0, error1, error0}, 66'd3);
    check("ovf_in_ready", {64'd0, in_ready1, in_ready0}, 66'd0);
    held = out_data1;
    repeat (2) @(posedge clk);
    #1;
    check("hold_out_nd", {65'd0, out_nd1}, 66'd1);
    check("hold_out_data", {33'd0, out_data1}, {33'd0, held});
    drain("ovf");
    check("ovf_error_sticky", {64'd0, error1, error0}, 66'd3);

    // Illegal counts.
    do_reset("illegal");
    send(rnd66(), 2'd0, 1'b0);
    check("cnt0_error", {64'd0, error1, error0}, 66'd3);
    do_reset("illegal3");
    send(rnd66(), 2'd3, 1'b0);
    check("cnt3_error", {64'd0, error1, error0}, 66'd3);
    repeat (5) @(posedge clk);
    #1;
    check("illegal_no_out", {64'd0, out_nd1, out_nd0}, 66'd0);

    // Reset with six slices in flight.
    do_reset("pre_mid");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd66(), 2'd2, 1'b1);
    check("mid_out_nd_before", {64'd0, out_nd1, out_nd0}, 66'd3);
    do_reset("mid");
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_no_stale", {64'd0, out_nd1, out_nd0}, 66'd0);
    send(rnd66(), 2'd2, 1'b1);
    drain("post_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
